// File: rtl/fifo_reader_pkg.sv
// Shared constants and types for the fifo_reader block: buffer depth,
// occupancy width and the pointer-wrap helper.
package fifo_reader_pkg;

    localparam int BUF_DEPTH = 3;
    localparam int OCC_WIDTH = 2;

    typedef logic [OCC_WIDTH-1:0] occ_t;
    // occ + inflight can reach BUF_DEPTH, so it gets one spare bit
    typedef logic [OCC_WIDTH:0]   level_t;

    localparam level_t DEPTH_LEVEL = level_t'(BUF_DEPTH);

    function automatic occ_t ptr_next(input occ_t ptr);
        return (ptr == occ_t'(BUF_DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/fifo_reader_if.sv
// Handshake bundle between the upstream FIFO, fifo_reader and the consumer.
// The master modport is the fifo_reader side; slave is the environment.
interface fifo_reader_if #(
    parameter int DATA_WIDTH = 8
);

    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_en;
    logic                  fifo_wait;
    logic [DATA_WIDTH-1:0] dataOut_data;
    logic                  dataOut_vld;
    logic                  dataOut_rd;

    modport master (
        input  fifo_data,
        input  fifo_wait,
        input  dataOut_rd,
        output fifo_en,
        output dataOut_data,
        output dataOut_vld
    );

    modport slave (
        output fifo_data,
        output fifo_wait,
        output dataOut_rd,
        input  fifo_en,
        input  dataOut_data,
        input  dataOut_vld
    );

endinterface

// File: rtl/fifo_reader_buf.sv
// Three-entry in-order skid buffer with wrapping head/tail pointers and a
// registered occupancy count; the head word is always presented on rd_data.
module fifo_reader_buf
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  vld,
    output occ_t                  occ
);

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    occ_t                  head;
    occ_t                  tail;
    occ_t                  occ_nxt;
    logic                  do_wr;
    logic                  do_rd;

    // A read with nothing buffered is ignored; a write into a full buffer
    // cannot be requested by the parent but is blocked here all the same.
    assign do_rd = rd_en && (occ != '0);
    assign do_wr = wr_en && (occ != occ_t'(BUF_DEPTH));

    always_comb begin
        // NOTE: default first so every path assigns occ_nxt; otherwise a latch is inferred.
        occ_nxt = occ;
        if (do_wr && !do_rd) begin
            occ_nxt = occ + 1'b1;
        end else if (!do_wr && do_rd) begin
            occ_nxt = occ - 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (do_wr) tail <= ptr_next(tail);
            if (do_rd) head <= ptr_next(head);
            occ <= occ_nxt;
        end
    end

    // NOTE: storage is deliberately not reset; occ and the pointers alone say what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) mem[tail] <= wr_data;
    end

    assign rd_data = mem[head];
    assign vld     = (occ != '0);

endmodule

// File: rtl/fifo_reader.sv
// Pulls words from a registered-output upstream FIFO into a 3-entry buffer.
// Define FIFO_READER_CNT_EN to add the words_cnt transfer counter port.
module fifo_reader
    import fifo_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fifo_reader_if.master        bus
`ifdef FIFO_READER_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0] words_cnt
`endif
);

    logic   inflight;
    logic   buf_vld;
    occ_t   occ;
    level_t committed;

    if (DATA_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
        $error("fifo_reader: DATA_WIDTH and CNT_WIDTH must be at least 1");
    end

    // Requests count the word still in flight, so the buffer can never be
    // over-committed; dataOut_rd deliberately plays no part here.
    assign committed   = level_t'(occ) + level_t'(inflight);
    assign bus.fifo_en = rst_n && !bus.fifo_wait && (committed < DEPTH_LEVEL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_en;
        end
    end

    fifo_reader_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (inflight),
        .wr_data (bus.fifo_data),
        .rd_en   (bus.dataOut_rd),
        .rd_data (bus.dataOut_data),
        .vld     (buf_vld),
        .occ     (occ)
    );

    assign bus.dataOut_vld = buf_vld;

`ifdef FIFO_READER_CNT_EN
    logic xfer;

    assign xfer = buf_vld && bus.dataOut_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            words_cnt <= '0;
        end else if (xfer) begin
            words_cnt <= words_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Self-checking bench for fifo_reader: an upstream FIFO model, a queue-based
// reference of the output stream, directed scenarios and a random phase.
module tb_fifo_reader;
    import fifo_reader_pkg::*;

    localparam int DW = 8;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_reader_if #(.DATA_WIDTH(DW)) bus ();
`ifdef FIFO_READER_CNT_EN
    logic [CW-1:0] words_cnt;
`endif

    fifo_reader #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FIFO_READER_CNT_EN
        ,
        .words_cnt (words_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] up_q[$];       // contents of the upstream FIFO
    logic [DW-1:0] mq[$];         // reference: words held for the consumer, oldest first
    bit            m_inflight;
    logic [DW-1:0] m_pending;
    int            m_cnt;         // reference transfer count since reset
    logic [DW-1:0] delivered[$];
    int            xfer_cyc[$];
    int            cyc;
    int            first_vld_cyc;
    int            accepts;
    bit            stall;
    bit            rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // One clock cycle: drive at the falling edge, compare, then advance the
    // reference and the upstream model just after the rising edge.
    task automatic step();
        bit acc;
        bit xfer;
        bit exp_en;
        @(negedge clk);
        bus.fifo_wait  = (up_q.size() == 0) || stall;
        bus.dataOut_rd = rd;
        #1;
        exp_en = !bus.fifo_wait && ((mq.size() + int'(m_inflight)) < BUF_DEPTH);
        check("fifo_en", bus.fifo_en, exp_en);
        check("dataOut_vld", bus.dataOut_vld, mq.size() > 0);
        if (mq.size() > 0) check("dataOut_data", bus.dataOut_data, mq[0]);
`ifdef FIFO_READER_CNT_EN
        check("words_cnt", words_cnt, m_cnt % (1 << CW));
`endif
        if (bus.dataOut_vld === 1'b1 && first_vld_cyc < 0) first_vld_cyc = cyc;
        acc  = (bus.fifo_en === 1'b1) && !bus.fifo_wait;
        xfer = (mq.size() > 0) && rd;
        if (xfer) begin
            delivered.push_back(mq[0]);
            xfer_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        if (xfer) begin
            void'(mq.pop_front());
            m_cnt++;
        end
        if (m_inflight) mq.push_back(m_pending);
        m_inflight = acc;
        if (acc) begin
            m_pending     = up_q.pop_front();
            bus.fifo_data = m_pending;
            accepts++;
        end
        cyc++;
    endtask

    task automatic apply_reset();
        rst_n         = 1'b0;
        bus.fifo_wait = 1'b0;
        #1;
        check("reset_vld", bus.dataOut_vld, 1'b0);
        check("reset_fifo_en", bus.fifo_en, 1'b0);
        mq.delete();
        m_inflight = 1'b0;
        m_cnt      = 0;
        repeat (2) @(negedge clk);
        bus.fifo_wait = 1'b1;
        rst_n = 1'b1;
    endtask

    task automatic start_scenario();
        delivered.delete();
        xfer_cyc.delete();
        first_vld_cyc = -1;
        accepts = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] w3 [3];
        logic [DW-1:0] w5 [5];
        logic [DW-1:0] w6 [6];
        int            cyc0;

        rst_n          = 1'b0;
        bus.fifo_wait  = 1'b1;
        bus.dataOut_rd = 1'b0;
        bus.fifo_data  = '0;
        stall = 1'b0;
        rd    = 1'b0;
        cyc   = 0;
        m_cnt = 0;
        @(negedge clk);
        apply_reset();

        // Basic read: three words with the consumer always ready
        start_scenario();
        w3 = '{8'h11, 8'h22, 8'h33};
        foreach (w3[i]) up_q.push_back(w3[i]);
        rd   = 1'b1;
        cyc0 = cyc;
        repeat (6) step();
        check("basic_first_vld_latency", first_vld_cyc - cyc0, 2);
        check("basic_count", delivered.size(), 3);
        if (delivered.size() == 3) begin
            foreach (w3[i]) check("basic_word", delivered[i], w3[i]);
            check("basic_back_to_back", xfer_cyc[2] - xfer_cyc[0], 2);
        end
`ifdef FIFO_READER_CNT_EN
        check("basic_words_cnt", words_cnt, 3);
`endif

        // Backpressure: five words upstream, consumer stalled
        start_scenario();
        w5 = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        foreach (w5[i]) up_q.push_back(w5[i]);
        rd = 1'b0;
        repeat (6) step();
        check("bp_accepts", accepts, 3);
        check("bp_occ_full", dut.u_buf.occ, 3);
        check("bp_fifo_en_low", bus.fifo_en, 1'b0);
        rd = 1'b1;
        repeat (10) step();
        check("bp_count", delivered.size(), 5);
        if (delivered.size() == 5) foreach (w5[i]) check("bp_word", delivered[i], w5[i]);

        // Empty upstream: consumer pulses must not underflow anything
        start_scenario();
        for (int i = 0; i < 8; i++) begin
            rd = i[0];
            step();
        end
        check("empty_count", delivered.size(), 0);
        check("empty_vld", bus.dataOut_vld, 1'b0);
        check("empty_occ", dut.u_buf.occ, 0);

        // Streaming: capture and transfer in the same cycle at occ=1
        start_scenario();
        w6 = '{8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6};
        foreach (w6[i]) up_q.push_back(w6[i]);
        rd = 1'b1;
        repeat (3) step();
        check("simul_occ_a", dut.u_buf.occ, 1);
        check("simul_inflight", dut.inflight, 1'b1);
        step();
        check("simul_occ_b", dut.u_buf.occ, 1);
        repeat (6) step();
        check("simul_count", delivered.size(), 6);
        if (delivered.size() == 6) begin
            foreach (w6[i]) check("simul_word", delivered[i], w6[i]);
            check("simul_rate", xfer_cyc[5] - xfer_cyc[0], 5);
        end

        // Reset mid-stream with occ=2 and a read in flight
        start_scenario();
        w5 = '{8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5};
        foreach (w5[i]) up_q.push_back(w5[i]);
        rd = 1'b0;
        repeat (3) step();
        check("rst_pre_occ", dut.u_buf.occ, 2);
        check("rst_pre_inflight", dut.inflight, 1'b1);
        apply_reset();
        delivered.delete();
        rd = 1'b1;
        repeat (8) step();
        check("rst_post_count", delivered.size(), 2);
        if (delivered.size() == 2) begin
            check("rst_post_word0", delivered[0], 8'hC4);
            check("rst_post_word1", delivered[1], 8'hC5);
        end

`ifdef FIFO_READER_CNT_EN
        // Counter wrap: 17 transfers on a 4-bit counter
        apply_reset();
        start_scenario();
        for (int i = 0; i < 17; i++) up_q.push_back(DW'(i + 8'h40));
        rd = 1'b1;
        repeat (24) step();
        check("wrap_transfers", delivered.size(), 17);
        check("wrap_words_cnt", words_cnt, 1);
`endif

        // Random traffic: upstream gaps, stalls, consumer backpressure, resets
        for (int i = 0; i < 3000; i++) begin
            if (up_q.size() < 4 && $urandom_range(0, 1) == 1) up_q.push_back(DW'($urandom));
            stall = ($urandom_range(0, 3) == 0);
            rd    = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 399) == 0) apply_reset();
            step();
        end
        stall = 1'b0;
        rd    = 1'b1;
        repeat (20) step();
        check("drain_empty", bus.dataOut_vld, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of every data word.
REQ-002 SHALL have parameter CNT_WIDTH, default 16: width of the words_cnt output.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port fifo_data, input, DATA_WIDTH: read data from the upstream FIFO, registered there, valid one cycle after an accepted read.
REQ-006 SHALL have port fifo_en, output, 1: read request to the upstream FIFO.
REQ-007 SHALL have port fifo_wait, input, 1: upstream FIFO is empty; a request is accepted only when fifo_wait=0.
REQ-008 SHALL have port dataOut_data, output, DATA_WIDTH: head word of the internal buffer.
REQ-009 SHALL have port dataOut_vld, output, 1: dataOut_data is valid.
REQ-010 SHALL have port dataOut_rd, input, 1: consumer ready; a transfer occurs when dataOut_vld=1 and dataOut_rd=1.
REQ-011 SHALL have port words_cnt, output, CNT_WIDTH: count of completed output transfers; present only with FIFO_READER_CNT_EN (see REQ-027).

Function
REQ-012 SHALL define an accepted read as fifo_en=1 and fifo_wait=0 in the same cycle.
REQ-013 SHALL set a registered inflight flag on each accepted read and clear it in the following cycle unless another read is accepted.
REQ-014 SHALL capture fifo_data into the buffer tail in the cycle when inflight=1, i.e. one cycle after acceptance, because read latency is exactly one cycle.
REQ-015 SHALL hold a 3-entry in-order buffer with a registered occupancy counter occ, range 0..3, width 2 bits.
REQ-016 SHALL drive fifo_en = (fifo_wait=0) AND (occ + inflight < 3), with no combinational path from dataOut_rd to fifo_en.
REQ-017 SHALL drive dataOut_vld = (occ > 0), registered-derived, with dataOut_data equal to the oldest buffered word.
REQ-018 SHALL hold dataOut_data stable while dataOut_vld=1 and dataOut_rd=0.
REQ-019 SHALL update occ per cycle as follows: capture only gives +1; transfer only gives -1; both in the same cycle leave occ unchanged and keep ordering; neither leaves occ unchanged.
REQ-020 SHALL sustain one word per cycle when upstream is non-empty and dataOut_rd=1 continuously, with a first-word latency of 2 cycles from the first accepted read to dataOut_vld=1.
REQ-021 SHALL never overflow: occ+inflight never exceeds 3, and a capture never occurs at occ=3.
REQ-022 SHALL wrap head and tail pointers modulo 3.
REQ-023 SHALL ignore dataOut_rd while dataOut_vld=0 (no underflow, occ stays 0).

Reset
REQ-024 SHALL, on rst_n=0, asynchronously clear occ, pointers, inflight and words_cnt, and force fifo_en=0 and dataOut_vld=0; buffer contents are undefined and dataOut_data is don't-care.
REQ-025 SHALL discard any in-flight read when reset is asserted mid-operation; after release, the first capture only follows a new accepted read.
REQ-026 SHALL not assert fifo_en in the first cycle after reset release unless fifo_wait=0.

Configuration
REQ-027 SHALL, when macro FIFO_READER_CNT_EN is defined, include words_cnt, which increments by 1 on every transfer, wraps from 2^CNT_WIDTH-1 to 0, and is reset to 0; without the macro, the words_cnt port and its counter are absent, and all other behaviour is identical.

Structure
REQ-028 SHALL place BUF_DEPTH=3 and the occupancy width constant (2) in shared package fifo_reader_pkg.
REQ-029 SHALL implement the 3-entry buffer, with its pointers and occ, as sub-module fifo_reader_buf; fifo_reader holds the request and inflight logic and the optional counter.

Verification
REQ-030 SHALL cover the basic read: upstream holds 0x11, 0x22, 0x33 and dataOut_rd=1 throughout -> fifo_en rises; dataOut_vld first at cycle 2; then 0x11, 0x22, 0x33 on consecutive cycles; words_cnt=3.
REQ-031 SHALL cover backpressure: upstream holds 5 words and dataOut_rd=0 -> exactly 3 reads accepted; fifo_en drops; occ=3. Then dataOut_rd=1 -> all 5 words delivered in order with no loss or duplication.
REQ-032 SHALL cover the empty upstream: fifo_wait=1 held -> no capture, dataOut_vld stays 0, and dataOut_rd pulses have no effect.
REQ-033 SHALL cover simultaneous capture and transfer: at occ=1, with one capture and one transfer in the same cycle -> occ stays 1 and the output order is preserved.
REQ-034 SHALL cover reset mid-stream: rst_n pulled low while inflight=1 and occ=2 -> dataOut_vld=0 immediately and no stale word appears after release.
REQ-035 SHALL cover counter wrap: with FIFO_READER_CNT_EN and CNT_WIDTH=4, 17 transfers -> words_cnt=1.
